// File: rtl/perceptron_pkg.sv
// Shared types, default sizes and arithmetic helpers for the perceptron classifier.
// PERCEPTRON_SAT_EN (see perceptron_mac) selects saturating accumulation.
package perceptron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int NUM_FEATURES_DEF = 7;
    localparam int NUM_CLASSES_DEF  = 10;
    localparam int FEAT_W_DEF       = 4;
    localparam int WGT_W_DEF        = 4;
    localparam int ACC_W_DEF        = 12;

    localparam int CLS_W  = $clog2(NUM_CLASSES_DEF);
    localparam int ADDR_W = $clog2(NUM_CLASSES_DEF * NUM_FEATURES_DEF);
    localparam int FIDX_W = $clog2(NUM_FEATURES_DEF);

    // Add and clamp to the signed range of a 'width'-bit accumulator.
    function automatic int sat_add(input int a, input int b, input int width);
        int sum;
        int hi;
        int lo;
        sum = a + b;
        hi  = (1 << (width - 1)) - 1;
        lo  = -(1 << (width - 1));
        if (sum > hi)
            sat_add = hi;
        else if (sum < lo)
            sat_add = lo;
        else
            sat_add = sum;
    endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Registered signed multiply-accumulate: unsigned feature x signed weight.
// PERCEPTRON_SAT_EN defined: clamp at the ACC_W signed limits; otherwise wrap.
module perceptron_mac
    import perceptron_pkg::*;
#(
    parameter int FEAT_W = FEAT_W_DEF,
    parameter int WGT_W  = WGT_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load,
    input  logic [FEAT_W-1:0]        feat,
    input  logic signed [WGT_W-1:0]  wgt,
    output logic signed [ACC_W-1:0]  acc
);

    int prod;
    int base;
    logic signed [ACC_W-1:0] acc_next;

    // Products are formed at full int width, so the sign extension happens before the add.
    always_comb begin
        prod = int'($signed({1'b0, feat})) * int'(wgt);
        base = load ? 0 : int'(acc);
`ifdef PERCEPTRON_SAT_EN
        acc_next = ACC_W'(sat_add(base, prod, ACC_W));
`else
        acc_next = ACC_W'(base + prod);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (en)
            acc <= acc_next;
    end

endmodule

// File: rtl/perceptron_classifier.sv
// Multi-class perceptron: serial per-class MAC over a latched feature vector, argmax output.
// Optional macro PERCEPTRON_SAT_EN enables saturating accumulation inside perceptron_mac.
module perceptron_classifier
    import perceptron_pkg::*;
#(
    parameter int NUM_FEATURES = NUM_FEATURES_DEF,
    parameter int NUM_CLASSES  = NUM_CLASSES_DEF,
    parameter int FEAT_W       = FEAT_W_DEF,
    parameter int WGT_W        = WGT_W_DEF,
    parameter int ACC_W        = ACC_W_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [NUM_FEATURES*FEAT_W-1:0]              in_features,
    input  logic                                        wr_en,
    output logic                                        wr_ready,
    input  logic [$clog2(NUM_CLASSES*NUM_FEATURES)-1:0] wr_addr,
    input  logic signed [WGT_W-1:0]                     wr_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [$clog2(NUM_CLASSES)-1:0]              out_class,
    output logic signed [ACC_W-1:0]                     out_score,
    output logic                                        busy
);

    localparam int CLASS_W = $clog2(NUM_CLASSES);
    localparam int WADDR_W = $clog2(NUM_CLASSES * NUM_FEATURES);
    localparam int FSEL_W  = $clog2(NUM_FEATURES);
    localparam int NWGT    = NUM_CLASSES * NUM_FEATURES;

    state_t state, state_next;
    logic [CLASS_W-1:0] cls_idx;
    logic [FSEL_W-1:0] feat_idx;
    logic [NUM_FEATURES*FEAT_W-1:0] feat_latch;
    logic signed [WGT_W-1:0] wgt [NWGT];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] best;
    logic [CLASS_W-1:0] best_cls;
    logic accept;
    logic last_feat;
    logic last_cls;
    logic [WADDR_W-1:0] rd_addr;
    logic [FEAT_W-1:0] feat_cur;

    assign busy      = (state == MAC) || (state == CMP);
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign wr_ready  = !busy;
    assign out_valid = (state == DONE);
    assign out_class = best_cls;
    assign out_score = best;
    assign accept    = in_valid && in_ready;
    assign last_feat = (feat_idx == FSEL_W'(NUM_FEATURES - 1));
    assign last_cls  = (cls_idx == CLASS_W'(NUM_CLASSES - 1));
    assign rd_addr   = WADDR_W'(int'(cls_idx) * NUM_FEATURES + int'(feat_idx));
    assign feat_cur  = feat_latch[int'(feat_idx)*FEAT_W +: FEAT_W];

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = MAC;
            MAC:  if (last_feat) state_next = CMP;
            CMP:  state_next = last_cls ? DONE : MAC;
            DONE: if (out_ready) state_next = accept ? MAC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Sequencing, feature latch and argmax tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_idx    <= '0;
            feat_idx   <= '0;
            feat_latch <= '0;
            best       <= '0;
            best_cls   <= '0;
        end else begin
            if (accept) begin
                cls_idx    <= '0;
                feat_idx   <= '0;
                feat_latch <= in_features;
            end else if (state == MAC) begin
                feat_idx <= last_feat ? '0 : feat_idx + 1'b1;
            end else if (state == CMP) begin
                // Strict compare keeps the lowest class index on ties.
                if ((cls_idx == '0) || (acc > best)) begin
                    best     <= acc;
                    best_cls <= cls_idx;
                end
                if (!last_cls)
                    cls_idx <= cls_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWGT; i++)
                wgt[i] <= '0;
        end else if (wr_en && wr_ready && (int'(wr_addr) < NWGT)) begin
            wgt[wr_addr] <= wr_data;
        end
    end

    perceptron_mac #(
        .FEAT_W(FEAT_W),
        .WGT_W (WGT_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == MAC),
        .load (feat_idx == '0),
        .feat (feat_cur),
        .wgt  (wgt[rd_addr]),
        .acc  (acc)
    );

endmodule

// File: tb/tb_perceptron_classifier.sv
// Directed and randomized bench for perceptron_classifier with an arithmetic reference model.
module tb_perceptron_classifier;
    import perceptron_pkg::*;

    localparam int NF  = 7;
    localparam int NC  = 10;
    localparam int FW  = 4;
    localparam int ACW = 12;
    localparam int LAT = NC * (NF + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic in_valid, in_ready, wr_en, wr_ready, out_valid, out_ready, busy;
    logic [NF*FW-1:0] in_features;
    logic [ADDR_W-1:0] wr_addr;
    logic signed [3:0] wr_data;
    logic [CLS_W-1:0] out_class;
    logic signed [ACW-1:0] out_score;

    logic in_valid2, in_ready2, wr_en2, wr_ready2, out_valid2, out_ready2, busy2;
    logic [15:0] in_features2;
    logic [5:0] wr_addr2;
    logic signed [3:0] wr_data2;
    logic [3:0] out_class2;
    logic signed [7:0] out_score2;

    perceptron_classifier dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_features(in_features), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_class(out_class), .out_score(out_score), .busy(busy)
    );

    perceptron_classifier #(.NUM_FEATURES(4), .NUM_CLASSES(10), .FEAT_W(4),
                            .WGT_W(4), .ACC_W(8)) dut_ovf (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_features(in_features2), .wr_en(wr_en2), .wr_ready(wr_ready2),
        .wr_addr(wr_addr2), .wr_data(wr_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_class(out_class2), .out_score(out_score2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    int wmod [NC*NF];

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int addacc(input int a, input int b, input int w);
        int s;
        int lim;
        s = a + b;
        lim = 1 << (w - 1);
`ifdef PERCEPTRON_SAT_EN
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
`else
        s = s & ((lim << 1) - 1);
        if (s >= lim) s = s - 2 * lim;
`endif
        return s;
    endfunction

    // Score every class with plain integer arithmetic and pick the first maximum.
    task automatic model(input logic [NF*FW-1:0] fv, output int cls, output int score);
        int s;
        int fval;
        logic [NF*FW-1:0] v;
        cls = 0;
        score = 0;
        v = fv;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int f = 0; f < NF; f++) begin
                fval = int'(v[f*FW +: FW]);
                s = addacc(s, fval * wmod[c*NF + f], ACW);
            end
            if (c == 0 || s > score) begin
                score = s;
                cls = c;
            end
        end
    endtask

    task automatic wr(input int addr, input int data);
        wr_addr = ADDR_W'(addr);
        wr_data = 4'(data);
        wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wmod[addr] = data;
    endtask

    task automatic wait_result(input string tag, input int cyc0, input int ecls, input int escore);
        int cyc;
        cyc = cyc0;
        while (!out_valid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, LAT);
        chk({tag, "_class"}, out_class, ecls);
        chk({tag, "_score"}, out_score, escore);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
    endtask

    task automatic start(input logic [NF*FW-1:0] fv);
        in_features = fv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_infer(input string tag, input logic [NF*FW-1:0] fv, input int ecls, input int escore);
        start(fv);
        wait_result(tag, 0, ecls, escore);
        handshake(tag);
    endtask

    initial begin
        logic [NF*FW-1:0] fv;
        logic [NF*FW-1:0] ones;
        int mc, ms, cyc;
        logic stable_ok, quiet_ok;
        logic [CLS_W-1:0] held_cls;
        logic signed [ACW-1:0] held_score;
        int ovf_score;

        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; wr_en = 0; wr_addr = '0; wr_data = '0; in_features = '0;
        in_valid2 = 0; out_ready2 = 0; wr_en2 = 0; wr_addr2 = '0; wr_data2 = '0; in_features2 = '0;
        for (int i = 0; i < NC*NF; i++) wmod[i] = 0;
        ones = '0;
        for (int f = 0; f < NF; f++) ones[f*FW +: FW] = 4'h1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_score", out_score, 0);
        run_infer("zero_wgt", ones, 0, 0);

        for (int f = 0; f < NF; f++) wr(3*NF + f, 1);
        fv = '0;
        for (int f = 0; f < NF; f++) fv[f*FW +: FW] = 4'd5;
        run_infer("argmax", fv, 3, 35);

        for (int f = 0; f < NF; f++) wr(3*NF + f, 0);
        wr(2*NF, -8);
        wr(5*NF, 7);
        wr(7*NF, 7);
        fv = '0;
        fv[3:0] = 4'd15;
        run_infer("signed_tie", fv, 5, 105);

        // Backpressure, then a handshake that re-enters MAC on the same edge.
        start(fv);
        wait_result("bp_first", 0, 5, 105);
        held_cls = out_class;
        held_score = out_score;
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 0);
            if (!out_valid || out_class !== held_cls || out_score !== held_score) stable_ok = 1'b0;
        end
        chk("bp_stable", stable_ok, 1);
        fv[3:0] = 4'd10;
        in_features = fv;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_valid", out_valid, 0);
        wait_result("b2b_second", 0, 5, 70);
        handshake("b2b_second");

        fv[3:0] = 4'd15;
        start(fv);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_wr_ready", wr_ready, 0);
        wr_addr = ADDR_W'(5*NF);
        wr_data = -4'sd8;
        wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_result("busy_wr_cur", 11, 5, 105);
        handshake("busy_wr_cur");
        run_infer("busy_wr_next", fv, 5, 105);

        // Weight write on the same edge as vector acceptance.
        wr(9*NF + 1, 1);
        fv = '0;
        fv[3:0] = 4'd15;
        fv[7:4] = 4'd15;
        wr_addr = ADDR_W'(9*NF);
        wr_data = 4'sd7;
        wr_en = 1'b1;
        start(fv);
        wr_en = 1'b0;
        wmod[9*NF] = 7;
        wait_result("wr_on_accept", 0, 9, 120);
        handshake("wr_on_accept");

        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < NC*NF; a++) wr(a, int'($urandom_range(15, 0)) - 8);
            fv = NF*FW'($urandom());
            model(fv, mc, ms);
            run_infer($sformatf("random%0d", r), fv, mc, ms);
        end

        // Overflow on the narrow-accumulator instance.
        for (int a = 0; a < 40; a++) begin
            wr_addr2 = 6'(a);
            wr_data2 = 4'sd7;
            wr_en2 = 1'b1;
            @(posedge clk); #1;
            wr_en2 = 1'b0;
        end
        ovf_score = 0;
        for (int f = 0; f < 4; f++) ovf_score = addacc(ovf_score, 15 * 7, 8);
`ifdef PERCEPTRON_SAT_EN
        chk("ovf_model", ovf_score, 127);
`else
        chk("ovf_model", ovf_score, -92);
`endif
        in_features2 = 16'hFFFF;
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        cyc = 0;
        while (!out_valid2 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ovf_latency", cyc, 50);
        chk("ovf_class", out_class2, 0);
        chk("ovf_score", out_score2, ovf_score);
        out_ready2 = 1'b1;
        @(posedge clk); #1;
        out_ready2 = 1'b0;

        // Reset in the middle of an inference.
        start(ones);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        quiet_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet_ok = 1'b0;
        end
        chk("midrst_quiet", quiet_ok, 1);
        for (int i = 0; i < NC*NF; i++) wmod[i] = 0;
        fv = NF*FW'($urandom());
        model(fv, mc, ms);
        run_infer("midrst_wgt_cleared", fv, mc, ms);
        chk("midrst_cleared_score", out_score, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
